// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared defaults and result-latency classes for the scoreboard hazard unit.
package scoreboard_hazard_unit_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int MAX_LAT_DEF  = 7;
   localparam int LAT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

   // Typical producer latencies, counted in cycles after EX.
   typedef enum logic [LAT_W_DEF-1:0] {
      LAT_ALU  = LAT_W_DEF'(0),
      LAT_LOAD = LAT_W_DEF'(1),
      LAT_MDU  = LAT_W_DEF'(MAX_LAT_DEF)
   } lat_class_e;

endpackage

// File: rtl/scoreboard_hazard_unit_reg_countdown.sv
// One scoreboard entry: cycles remaining until a pending result becomes forwardable.
module scoreboard_hazard_unit_reg_countdown
   import scoreboard_hazard_unit_pkg::*;
#(
   parameter int CW = LAT_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          clear,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] ONE = CW'(1);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard unit: per-register pending-result scoreboard driving freeze/flush and issue.
module scoreboard_hazard_unit
   import scoreboard_hazard_unit_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int MAX_LAT  = MAX_LAT_DEF,
   parameter  int PERF_W   = 32,
   localparam int RW       = $clog2(NUM_REGS),
   localparam int CW       = $clog2(MAX_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [RW-1:0]     id_rs1,
   input  logic [RW-1:0]     id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [RW-1:0]     id_rd,
   input  logic              id_reg_write,
   input  logic [CW-1:0]     id_lat,
   input  logic              id_branch,
   input  logic              id_is_mdu,
   input  logic              mdu_busy,
   input  logic              jump_id,
   input  logic              pc_src_ex,
   output logic              stall_if,
   output logic              stall_id,
   output logic              flush_id,
   output logic              flush_ex,
   output logic              issue,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam int            NUM_IDX  = 2 ** RW;
   localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

   logic [CW-1:0]     cnt [NUM_IDX];
   logic [CW-1:0]     lat_sat;
   logic              ex_wr;
   logic [RW-1:0]     ex_rd;
   logic [PERF_W-1:0] stall_cnt;

   logic dep_rs1, dep_rs2, waw, struct_haz, hazard;
   logic stall_req, flush_id_req, flush_ex_req, issue_req;
   logic sb_write, sb_squash;

   // ---------------------------------------------------------------- hazard terms
   // The branch term catches an ALU result still sitting in EX, which the countdown never sees.
   assign dep_rs1 = id_use_rs1 && (id_rs1 != '0) &&
                    ((cnt[id_rs1] != '0) || (id_branch && ex_wr && (ex_rd == id_rs1)));
   assign dep_rs2 = id_use_rs2 && (id_rs2 != '0) &&
                    ((cnt[id_rs2] != '0) || (id_branch && ex_wr && (ex_rd == id_rs2)));

   assign waw        = id_reg_write && (id_rd != '0) && (cnt[id_rd] != '0);
   assign struct_haz = id_is_mdu && mdu_busy;
   assign hazard     = id_valid && (dep_rs1 || dep_rs2 || waw || struct_haz);

   // ---------------------------------------------------------------- pipeline control
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stall_req    = 1'b0;
      flush_id_req = 1'b0;
      flush_ex_req = 1'b0;
      issue_req    = 1'b0;
      if (pc_src_ex) begin
         flush_id_req = 1'b1;
         flush_ex_req = 1'b1;
      end else if (hazard) begin
         stall_req    = 1'b1;
         flush_ex_req = 1'b1;
      end else if (jump_id && id_valid) begin
         flush_id_req = 1'b1;
         issue_req    = 1'b1;
      end else begin
         issue_req    = id_valid;
      end
   end

   assign stall_if     = rst_n & stall_req;
   assign stall_id     = rst_n & stall_req;
   assign flush_id     = rst_n & flush_id_req;
   assign flush_ex     = rst_n & flush_ex_req;
   assign issue        = rst_n & issue_req;
   assign stall_cycles = rst_n ? stall_cnt : '0;

   // ---------------------------------------------------------------- scoreboard
   assign lat_sat   = (32'(id_lat) > MAX_LAT) ? CW'(MAX_LAT) : id_lat;
   assign sb_write  = issue_req && id_reg_write && (id_rd != '0);
   // A squashed EX producer is the newest writer of ex_rd, so its entry can be dropped outright.
   assign sb_squash = pc_src_ex && ex_wr;

   for (genvar r = 0; r < NUM_IDX; r++) begin : g_sb
      if (r == 0 || r >= NUM_REGS) begin : g_none
         assign cnt[r] = '0;
      end else begin : g_entry
         scoreboard_hazard_unit_reg_countdown #(
            .CW (CW)
         ) u_cd (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (sb_write && (id_rd == RW'(r))),
            .load_val (lat_sat),
            .clear    (sb_squash && (ex_rd == RW'(r))),
            .count    (cnt[r])
         );
      end
   end

   // ---------------------------------------------------------------- EX occupant and perf counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_wr     <= 1'b0;
         ex_rd     <= '0;
         stall_cnt <= '0;
      end else begin
         ex_wr <= sb_write;
         ex_rd <= id_rd;
         if (!pc_src_ex && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_ONE;
         end
      end
   end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed scenarios plus randomized traffic against a pending-cycles model.
module tb_scoreboard_hazard_unit;
   import scoreboard_hazard_unit_pkg::*;

   localparam int RW      = 5;
   localparam int CW      = 3;
   localparam int PERF_W  = 32;
   localparam int MAX_LAT = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              id_valid = 1'b0;
   logic [RW-1:0]     id_rs1 = '0;
   logic [RW-1:0]     id_rs2 = '0;
   logic              id_use_rs1 = 1'b0;
   logic              id_use_rs2 = 1'b0;
   logic [RW-1:0]     id_rd = '0;
   logic              id_reg_write = 1'b0;
   logic [CW-1:0]     id_lat = '0;
   logic              id_branch = 1'b0;
   logic              id_is_mdu = 1'b0;
   logic              mdu_busy = 1'b0;
   logic              jump_id = 1'b0;
   logic              pc_src_ex = 1'b0;
   logic              stall_if, stall_id, flush_id, flush_ex, issue;
   logic [PERF_W-1:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   scoreboard_hazard_unit #(
      .NUM_REGS (32),
      .MAX_LAT  (MAX_LAT),
      .PERF_W   (PERF_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_lat       (id_lat),
      .id_branch    (id_branch),
      .id_is_mdu    (id_is_mdu),
      .mdu_busy     (mdu_busy),
      .jump_id      (jump_id),
      .pc_src_ex    (pc_src_ex),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .flush_id     (flush_id),
      .flush_ex     (flush_ex),
      .issue        (issue),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   // Each register holds the number of cycles its pending result still needs.
   int      m_cnt [32];
   bit      m_ex_wr = 1'b0;
   int      m_ex_rd = 0;
   longint  m_stalls = 0;
   bit      e_dep1, e_dep2, e_waw, e_struct, e_hazard, e_stall, e_jump, e_issue, e_write;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_stall_if", stall_if, 0);
         check("rst_stall_id", stall_id, 0);
         check("rst_flush_id", flush_id, 0);
         check("rst_flush_ex", flush_ex, 0);
         check("rst_issue", issue, 0);
         check("rst_stall_cycles", stall_cycles, 0);
         foreach (m_cnt[r]) m_cnt[r] = 0;
         m_ex_wr  = 1'b0;
         m_ex_rd  = 0;
         m_stalls = 0;
      end else begin
         e_dep1   = id_use_rs1 && id_rs1 != 0 &&
                    (m_cnt[id_rs1] > 0 || (id_branch && m_ex_wr && m_ex_rd == int'(id_rs1)));
         e_dep2   = id_use_rs2 && id_rs2 != 0 &&
                    (m_cnt[id_rs2] > 0 || (id_branch && m_ex_wr && m_ex_rd == int'(id_rs2)));
         e_waw    = id_reg_write && id_rd != 0 && m_cnt[id_rd] > 0;
         e_struct = id_is_mdu && mdu_busy;
         e_hazard = id_valid && (e_dep1 || e_dep2 || e_waw || e_struct);
         e_stall  = !pc_src_ex && e_hazard;
         e_jump   = !pc_src_ex && !e_hazard && jump_id && id_valid;
         e_issue  = !pc_src_ex && !e_hazard && id_valid;

         check("stall_if", stall_if, 64'(e_stall));
         check("stall_id", stall_id, 64'(e_stall));
         check("flush_id", flush_id, 64'(pc_src_ex || e_jump));
         check("flush_ex", flush_ex, 64'(pc_src_ex || e_stall));
         check("issue", issue, 64'(e_issue));
         check("stall_cycles", stall_cycles, 64'(m_stalls));

         foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
         if (pc_src_ex && m_ex_wr) m_cnt[m_ex_rd] = 0;
         e_write = e_issue && id_reg_write && id_rd != 0;
         if (e_write) m_cnt[id_rd] = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
         m_ex_wr = e_write;
         m_ex_rd = int'(id_rd);
         if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   task automatic put(input bit v, input int rd, input bit wr, input int lat,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input bit br, input bit mdu, input bit jmp);
      id_valid     = v;
      id_rd        = RW'(rd);
      id_reg_write = wr;
      id_lat       = CW'(lat);
      id_rs1       = RW'(rs1);
      id_use_rs1   = u1;
      id_rs2       = RW'(rs2);
      id_use_rs2   = u2;
      id_branch    = br;
      id_is_mdu    = mdu;
      jump_id      = jmp;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Hold the current ID instruction until it issues; the stall count seen is compared to exp_stalls.
   task automatic wait_issue(input string name, input int exp_stalls);
      int  stalls = 0;
      bit  seen   = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (issue === 1'b1) seen = 1'b1;
         else stalls++;
         next_cycle();
      end
      check(name, 64'(stalls), 64'(exp_stalls));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Load -> use: one bubble.
      put(1, 5, 1, LAT_LOAD, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("lw_x5_issue", 0);
      put(1, 6, 1, LAT_ALU, 5, 1, 2, 1, 0, 0, 0);
      wait_issue("load_use_stalls", 1);
      @(negedge clk);
      check("load_use_stall_cycles", stall_cycles, 1);
      next_cycle();

      // ALU -> branch stalls once; ALU -> non-branch does not.
      put(1, 3, 1, LAT_ALU, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("add_x3_issue", 0);
      put(1, 0, 0, LAT_ALU, 3, 1, 0, 1, 1, 0, 0);
      wait_issue("alu_branch_stalls", 1);
      put(1, 3, 1, LAT_ALU, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("add_x3_again", 0);
      put(1, 4, 1, LAT_ALU, 3, 1, 0, 0, 0, 0, 0);
      wait_issue("alu_nonbranch_stalls", 0);

      // MDU WAW, then consumer behind an independent op.
      put(1, 7, 1, 6, 1, 1, 2, 1, 0, 1, 0);
      wait_issue("div_x7_issue", 0);
      put(1, 7, 1, LAT_ALU, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("waw_stalls", 6);
      put(1, 7, 1, 6, 1, 1, 2, 1, 0, 1, 0);
      wait_issue("div_x7_reissue", 0);
      put(1, 8, 1, LAT_ALU, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("independent_issue", 0);
      put(1, 10, 1, LAT_ALU, 7, 1, 1, 1, 0, 0, 0);
      wait_issue("mdu_consumer_stalls", 5);

      // Redirect squashes a load in EX and releases its destination.
      put(1, 9, 1, LAT_LOAD, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("lw_x9_issue", 0);
      put(1, 12, 1, LAT_ALU, 9, 1, 0, 0, 0, 0, 0);
      pc_src_ex = 1'b1;
      @(negedge clk);
      check("redirect_flush_id", flush_id, 1);
      check("redirect_flush_ex", flush_ex, 1);
      check("redirect_stall_if", stall_if, 0);
      check("redirect_issue", issue, 0);
      next_cycle();
      pc_src_ex = 1'b0;
      wait_issue("redirect_reader_stalls", 0);

      // Busy multi-cycle unit: three structural stalls.
      put(1, 0, 0, LAT_ALU, 1, 1, 2, 1, 0, 1, 0);
      mdu_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("struct_stall", stall_if, 1);
         next_cycle();
      end
      mdu_busy = 1'b0;
      wait_issue("struct_release", 0);
      @(negedge clk);
      check("struct_stall_cycles", stall_cycles, 16);
      next_cycle();

      // JAL without and with a pending dependency.
      put(1, 31, 1, LAT_ALU, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("jal_flush_id", flush_id, 1);
      check("jal_issue", issue, 1);
      next_cycle();
      put(1, 11, 1, LAT_LOAD, 1, 1, 2, 1, 0, 0, 0);
      wait_issue("lw_x11_issue", 0);
      put(1, 31, 1, LAT_ALU, 11, 1, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("jal_dep_stall", stall_if, 1);
      check("jal_dep_no_flush", flush_id, 0);
      next_cycle();
      @(negedge clk);
      check("jal_dep_flush_id", flush_id, 1);
      check("jal_dep_issue", issue, 1);
      next_cycle();

      // Reset while x5 has four cycles outstanding.
      put(1, 5, 1, 4, 1, 1, 2, 1, 0, 1, 0);
      wait_issue("div_x5_issue", 0);
      put(1, 13, 1, LAT_ALU, 5, 1, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_stall_if", stall_if, 0);
      check("midrst_issue", issue, 0);
      check("midrst_stall_cycles", stall_cycles, 0);
      next_cycle();
      rst_n = 1'b1;
      wait_issue("post_reset_reader_stalls", 0);
      put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("post_reset_stall_cycles", stall_cycles, 0);
      next_cycle();

      // Randomized traffic on a small register window to provoke hazards.
      for (int c = 0; c < 3000; c++) begin
         int lsel;
         rst_n        = ($urandom_range(0, 199) != 0);
         id_valid     = ($urandom_range(0, 3) != 0);
         id_rs1       = RW'($urandom_range(0, 7));
         id_rs2       = RW'($urandom_range(0, 7));
         id_use_rs1   = $urandom_range(0, 1);
         id_use_rs2   = $urandom_range(0, 1);
         id_rd        = RW'($urandom_range(0, 7));
         id_reg_write = $urandom_range(0, 1);
         lsel         = $urandom_range(0, 3);
         case (lsel)
            0:       id_lat = LAT_ALU;
            1:       id_lat = LAT_LOAD;
            2:       id_lat = LAT_MDU;
            default: id_lat = CW'($urandom_range(0, 7));
         endcase
         id_branch    = ($urandom_range(0, 3) == 0);
         id_is_mdu    = ($urandom_range(0, 3) == 0);
         mdu_busy     = ($urandom_range(0, 3) == 0);
         jump_id      = ($urandom_range(0, 15) == 0);
         pc_src_ex    = ($urandom_range(0, 15) == 0);
         next_cycle();
      end

      rst_n = 1'b1;
      pc_src_ex = 1'b0;
      put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
